gpio_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single GPIO peripheral port (req/gnt/rvalid protocol) between the core data port (m0) and a secondary master such as debug or DMA (m1). It grants round-robin and records the owner of each granted transfer in an ordered owner FIFO. Each slave response is routed back to the master that issued it. It sits between the interconnect address decode and the GPIO peripheral.

---
 rtl/gpio_bus_arbiter_if.sv | 15 +
 rtl/gpio_bus_arbiter.sv | 109 ++++++++++
 tb/tb_gpio_bus_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_arbiter_if.sv
// One req/gnt/rvalid bus port. The arbiter uses the slave view toward each master
// and the master view toward the GPIO peripheral.
interface gpio_bus_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, write, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, write, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO req/gnt/rvalid port between two masters.
// An ordered owner FIFO routes each response back to the master that issued it.
module gpio_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUT    = 2
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    gpio_bus_arbiter_if.slave  m0,
    gpio_bus_arbiter_if.slave  m1,
    gpio_bus_arbiter_if.master s,
    output logic               s_sel,
    output logic               err
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_e;

    owner_e        prio_q, prio_d;
    owner_e        fifo_q [MAX_OUT];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          full;
    logic          win_valid;
    owner_e        winner;
    owner_e        head;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        winner    = prio_q;
        full      = (count_q == CW'(MAX_OUT));
        win_valid = !full && (m0.req || m1.req);
        head      = fifo_q[rd_ptr_q];
        pop       = s.rvalid && (count_q != '0);

        if (m0.req && !m1.req) winner = OWN_M0;
        else if (m1.req && !m0.req) winner = OWN_M1;

        push = win_valid && s.gnt;

        // Request side never depends on s.rvalid/s.rdata, keeping rvalid off the grant path.
        s.req   = win_valid;
        s_sel   = win_valid;
        s.write = 1'b0;
        s.wdata = '0;
        if (win_valid) begin
            s.write = (winner == OWN_M1) ? m1.write : m0.write;
            s.wdata = (winner == OWN_M1) ? m1.wdata : m0.wdata;
        end

        m0.gnt    = push && (winner == OWN_M0);
        m1.gnt    = push && (winner == OWN_M1);
        m0.rvalid = pop && (head == OWN_M0);
        m1.rvalid = pop && (head == OWN_M1);
        m0.rdata  = (pop && (head == OWN_M0)) ? s.rdata : '0;
        m1.rdata  = (pop && (head == OWN_M1)) ? s.rdata : '0;

        prio_d   = prio_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            prio_d   = (winner == OWN_M0) ? OWN_M1 : OWN_M0;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        err_d = err_q || (s.rvalid && (count_q == '0));
    end

    assign err = err_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prio_q   <= OWN_M0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values regardless of statement order.
            prio_q   <= prio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // NOTE: owner storage has no reset; count_q gates every read, so stale entries are never observed.
    always_ff @(posedge HCLK) begin
        if (push) fifo_q[wr_ptr_q] <= winner;
    end
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench for gpio_bus_arbiter: directed scenarios plus random traffic
// compared against a queue-based model of the arbitration and routing rules.
module tb_gpio_bus_arbiter;
    localparam int DW      = 32;
    localparam int MAX_OUT = 2;

    logic HCLK;
    logic HRESETn;
    logic s_sel;
    logic err;

    gpio_bus_arbiter_if #(.DATA_WIDTH(DW)) m0_bus ();
    gpio_bus_arbiter_if #(.DATA_WIDTH(DW)) m1_bus ();
    gpio_bus_arbiter_if #(.DATA_WIDTH(DW)) s_bus ();

    gpio_bus_arbiter #(.DATA_WIDTH(DW), .MAX_OUT(MAX_OUT)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .s_sel   (s_sel),
        .err     (err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: ordered queue of owners, favoured master, sticky error.
    bit mq[$];
    bit m_prio = 1'b0;
    bit m_err  = 1'b0;
    bit last_hs = 1'b0;
    int n_grants = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [DW-1:0] d0,
                         input bit r1, input bit w1, input logic [DW-1:0] d1,
                         input bit sg, input bit sv, input logic [DW-1:0] sd);
        m0_bus.req = r0; m0_bus.write = w0; m0_bus.wdata = d0;
        m1_bus.req = r1; m1_bus.write = w1; m1_bus.wdata = d1;
        s_bus.gnt = sg; s_bus.rvalid = sv; s_bus.rdata = sd;
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, '0, 0, 0, '0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "/m0_gnt"},    32'(m0_bus.gnt),    0);
        check({tag, "/m1_gnt"},    32'(m1_bus.gnt),    0);
        check({tag, "/m0_rvalid"}, 32'(m0_bus.rvalid), 0);
        check({tag, "/m1_rvalid"}, 32'(m1_bus.rvalid), 0);
        check({tag, "/m0_rdata"},  m0_bus.rdata,       0);
        check({tag, "/m1_rdata"},  m1_bus.rdata,       0);
        check({tag, "/s_req"},     32'(s_bus.req),     0);
        check({tag, "/s_sel"},     32'(s_sel),         0);
        check({tag, "/s_write"},   32'(s_bus.write),   0);
        check({tag, "/s_wdata"},   s_bus.wdata,        0);
        check({tag, "/err"},       32'(err),           0);
    endtask

    // One clock cycle: inputs are already driven; outputs checked at the falling edge,
    // model advanced at the rising edge.
    task automatic step(input string tag);
        int n;
        bit any, w, ev, hs, pop, hd;
        logic [DW-1:0] e_wdata;
        @(negedge HCLK);
        n   = mq.size();
        any = m0_bus.req || m1_bus.req;
        w   = (m0_bus.req && m1_bus.req) ? m_prio : m1_bus.req;
        ev  = (n < MAX_OUT) && any;
        hs  = ev && s_bus.gnt;
        pop = s_bus.rvalid && (n > 0);
        hd  = (n > 0) ? mq[0] : 1'b0;
        e_wdata = !ev ? '0 : (w ? m1_bus.wdata : m0_bus.wdata);
        check({tag, "/m0_gnt"},    32'(m0_bus.gnt),    32'(hs && !w));
        check({tag, "/m1_gnt"},    32'(m1_bus.gnt),    32'(hs && w));
        check({tag, "/m0_rvalid"}, 32'(m0_bus.rvalid), 32'(pop && !hd));
        check({tag, "/m1_rvalid"}, 32'(m1_bus.rvalid), 32'(pop && hd));
        check({tag, "/m0_rdata"},  m0_bus.rdata,       (pop && !hd) ? s_bus.rdata : '0);
        check({tag, "/m1_rdata"},  m1_bus.rdata,       (pop && hd) ? s_bus.rdata : '0);
        check({tag, "/s_req"},     32'(s_bus.req),     32'(ev));
        check({tag, "/s_sel"},     32'(s_sel),         32'(ev));
        check({tag, "/s_write"},   32'(s_bus.write),   32'(ev && (w ? m1_bus.write : m0_bus.write)));
        check({tag, "/s_wdata"},   s_bus.wdata,        e_wdata);
        check({tag, "/err"},       32'(err),           32'(m_err));
        @(posedge HCLK);
        if (pop) void'(mq.pop_front());
        if (hs) begin
            mq.push_back(w);
            m_prio = !w;
            n_grants++;
        end
        if (s_bus.rvalid && n == 0) m_err = 1'b1;
        last_hs = hs;
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_prio  = 1'b0;
        m_err   = 1'b0;
        last_hs = 1'b0;
    endtask

    initial begin
        int g0;
        // Reset with idle masters and a stray s_rvalid: every output must stay 0.
        HRESETn = 1'b0;
        drive(0, 0, '0, 0, 0, '0, 1, 1, 32'hDEAD_BEEF);
        #3;
        check_idle("reset");
        @(negedge HCLK);
        idle();
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Single m0 write, then its response.
        drive(1, 1, 32'h0000_A5A5, 0, 0, '0, 1, 0, '0);
        #1;
        check("single/m0_gnt",  32'(m0_bus.gnt),  1);
        check("single/s_write", 32'(s_bus.write), 1);
        check("single/s_wdata", s_bus.wdata,      32'h0000_A5A5);
        step("single_req");
        drive(0, 0, '0, 0, 0, '0, 1, 1, 32'h0000_5555);
        #1;
        check("single/m0_rvalid", 32'(m0_bus.rvalid), 1);
        check("single/m1_rvalid", 32'(m1_bus.rvalid), 0);
        step("single_rsp");

        // Both masters requesting continuously with a 1-cycle GPIO response.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1'($urandom), $urandom, 1, 1'($urandom), $urandom, 1, last_hs, $urandom);
            step("rr");
        end
        drive(0, 0, '0, 0, 0, '0, 1, last_hs, $urandom);
        step("rr_drain");

        // No responses: two grants fill the FIFO, then stall.
        g0 = n_grants;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, $urandom, 1, 1, $urandom, 1, 0, '0);
            step("full");
        end
        check("full/grants", 32'(n_grants - g0), 2);
        drive(1, 0, $urandom, 1, 1, $urandom, 1, 1, 32'h0000_0077);
        step("full_pop");
        check("full_pop/grants", 32'(n_grants - g0), 2);
        drive(1, 0, $urandom, 1, 1, $urandom, 1, 0, '0);
        step("full_regrant");
        check("full_regrant/grants", 32'(n_grants - g0), 3);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, '0, 0, 0, '0, 1, 1, $urandom);
            step("full_drain");
        end

        // m1 read and routed read data.
        drive(0, 0, '0, 1, 0, 32'h1111_0000, 1, 0, '0);
        step("m1_read");
        drive(0, 0, '0, 0, 0, '0, 1, 1, 32'h0000_1234);
        #1;
        check("m1_read/m1_rdata", m1_bus.rdata, 32'h0000_1234);
        check("m1_read/m0_rdata", m0_bus.rdata, 0);
        step("m1_rsp");

        // Response with empty FIFO sets sticky err; later traffic still works.
        drive(0, 0, '0, 0, 0, '0, 1, 1, 32'hBAD0_BAD0);
        step("err_set");
        check("err/after", 32'(err), 1);
        drive(1, 1, 32'h0000_00E1, 0, 0, '0, 1, 0, '0);
        step("err_xfer");
        drive(0, 0, '0, 0, 0, '0, 1, 1, 32'h0000_00E2);
        step("err_rsp");
        check("err/sticky", 32'(err), 1);

        // Reset with one transfer outstanding.
        drive(0, 0, '0, 1, 1, 32'h0000_0CC0, 1, 0, '0);
        step("rst_out");
        idle();
        HRESETn = 1'b0;
        #1;
        check_idle("mid_reset");
        model_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        g0 = n_grants;
        drive(1, 1, 32'h0000_0001, 1, 1, 32'h0000_0002, 1, 0, '0);
        #1;
        check("post_reset/m0_first", 32'(m0_bus.gnt), 1);
        step("post_reset0");
        step("post_reset1");
        check("post_reset/grants", 32'(n_grants - g0), 2);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, '0, 0, 0, '0, 1, 1, $urandom);
            step("post_reset_drain");
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                  1'($urandom_range(0, 3) != 0),
                  (mq.size() > 0) ? 1'($urandom) : 1'b0, $urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
